// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: function codes, flag encodings,
// arbiter FSM states and the flag derivation helper.
package alu_pkg;

  localparam logic [3:0] FN_AND   = 4'b0000;
  localparam logic [3:0] FN_OR    = 4'b0001;
  localparam logic [3:0] FN_XOR   = 4'b0010;
  localparam logic [3:0] FN_ADD   = 4'b0011;
  localparam logic [3:0] FN_SUB   = 4'b0100;
  localparam logic [3:0] FN_CMP   = 4'b0101;
  localparam logic [3:0] FN_NOT   = 4'b0110;
  localparam logic [3:0] FN_SHL16 = 4'b0111;
  localparam logic [3:0] FN_MULT  = 4'b1000;
  localparam logic [3:0] FN_NOP   = 4'b1111;

  localparam logic [1:0] FLAG_POS  = 2'b00;
  localparam logic [1:0] FLAG_ZERO = 2'b01;
  localparam logic [1:0] FLAG_NEG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Zero takes precedence; a zero result can never also be negative.
  function automatic logic [1:0] flags_of(input logic is_zero, input logic is_neg);
    if (is_zero) return FLAG_ZERO;
    if (is_neg)  return FLAG_NEG;
    return FLAG_POS;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Two-input round-robin grant. The pointer only moves when both requesters
// compete, so an uncontested requester never costs the other its turn.
module rr_grant2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && req_i == 2'b11) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: round-robin grant, registered
// ALU operands, result capture (multi-cycle for MULT) and the compare-flags register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  input  logic [3:0]       Req0Func,
  output logic             Resp0Valid,
  input  logic             Resp0Ready,
  output logic [WIDTH-1:0] Resp0Result,
  output logic             Resp0Err,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  input  logic [3:0]       Req1Func,
  output logic             Resp1Valid,
  input  logic             Resp1Ready,
  output logic [WIDTH-1:0] Resp1Result,
  output logic             Resp1Err,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [3:0]       AluFunc,
  input  logic [WIDTH-1:0] AluResult,
  output logic [1:0]       Flags,
  output logic             Busy
);
  localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_func_q, alu_func_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [1:0]       flags_q, flags_d;
  logic [1:0]       gnt;
  logic [3:0]       func_sel;
  logic             undef_op;
  logic             resp0_vld, resp1_vld;

  rr_grant2 u_grant (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == ST_IDLE),
    .req_i ({Req1Valid, Req0Valid}),
    .gnt_o (gnt)
  );

  assign func_sel = gnt[1] ? Req1Func : Req0Func;
  assign undef_op = alu_func_q > FN_MULT;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    err_d      = err_q;
    flags_d    = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d    = gnt[1];
          alu_a_d    = gnt[1] ? Req1A : Req0A;
          alu_b_d    = gnt[1] ? Req1B : Req0B;
          alu_func_d = func_sel;
          cnt_d      = (func_sel == FN_MULT) ? CW'(MULT_CYCLES - 1) : '0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          err_d    = undef_op;
          result_d = undef_op ? '0 : AluResult;
          if (alu_func_q == FN_CMP)
            flags_d = flags_of(AluResult == '0, AluResult[WIDTH-1]);
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (owner_q ? Resp1Ready : Resp0Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= FN_NOP;
      cnt_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      flags_q    <= FLAG_POS;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      err_q      <= err_d;
      flags_q    <= flags_d;
    end
  end

  // Response outputs are gated by ownership so the idle port always reads zero.
  assign resp0_vld   = (state_q == ST_RESP) && !owner_q;
  assign resp1_vld   = (state_q == ST_RESP) &&  owner_q;
  assign Req0Ready   = gnt[0] & ~rst;
  assign Req1Ready   = gnt[1] & ~rst;
  assign Resp0Valid  = resp0_vld;
  assign Resp1Valid  = resp1_vld;
  assign Resp0Result = resp0_vld ? result_q : '0;
  assign Resp1Result = resp1_vld ? result_q : '0;
  assign Resp0Err    = resp0_vld & err_q;
  assign Resp1Err    = resp1_vld & err_q;
  assign AluA        = alu_a_q;
  assign AluB        = alu_b_q;
  assign AluFunc     = alu_func_q;
  assign Flags       = flags_q;
  assign Busy        = state_q != ST_IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a stand-in ALU that only yields a
// correct MULT product once its inputs have been stable for MULT_CYCLES cycles.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int MC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_err;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_err;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
  logic [3:0]  req0_func, req1_func, alu_func;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  flags;
  logic        busy;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .Req0Valid(req0_valid), .Req0Ready(req0_ready), .Req0A(req0_a), .Req0B(req0_b),
    .Req0Func(req0_func), .Resp0Valid(resp0_valid), .Resp0Ready(resp0_ready),
    .Resp0Result(resp0_result), .Resp0Err(resp0_err),
    .Req1Valid(req1_valid), .Req1Ready(req1_ready), .Req1A(req1_a), .Req1B(req1_b),
    .Req1Func(req1_func), .Resp1Valid(resp1_valid), .Resp1Ready(resp1_ready),
    .Resp1Result(resp1_result), .Resp1Err(resp1_err),
    .AluA(alu_a), .AluB(alu_b), .AluFunc(alu_func), .AluResult(alu_result),
    .Flags(flags), .Busy(busy)
  );

  // Stand-in ALU; undefined codes return junk so the arbiter must zero them.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
    case (f)
      FN_AND:         return a & b;
      FN_OR:          return a | b;
      FN_XOR:         return a ^ b;
      FN_ADD:         return a + b;
      FN_SUB, FN_CMP: return a - b;
      FN_NOT:         return ~a;
      FN_SHL16:       return a << 16;
      FN_MULT:        return a * b;
      FN_NOP:         return 32'h0;
      default:        return 32'hA5A5_A5A5;
    endcase
  endfunction

  int          mult_age = 0;
  logic [31:0] pa = '0, pb = '0;
  logic [3:0]  pf = '0;
  always @(posedge clk) begin
    #1;
    if (alu_a !== pa || alu_b !== pb || alu_func !== pf) mult_age <= 0;
    else                                                 mult_age <= mult_age + 1;
    pa <= alu_a;
    pb <= alu_b;
    pf <= alu_func;
  end
  always @* begin
    if (alu_func == FN_MULT && mult_age < MC - 1) alu_result = 32'hDEAD_BEEF;
    else                                          alu_result = alu_ref(alu_a, alu_b, alu_func);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction
  function automatic logic rvalid(input int p);
    return (p == 0) ? resp0_valid : resp1_valid;
  endfunction
  function automatic logic [31:0] rres(input int p);
    return (p == 0) ? resp0_result : resp1_result;
  endfunction
  function automatic logic rerr(input int p);
    return (p == 0) ? resp0_err : resp1_err;
  endfunction

  task automatic drive(input int p, input logic v, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin req0_valid = v; req0_func = f; req0_a = a; req0_b = b; end
    else        begin req1_valid = v; req1_func = f; req1_a = a; req1_b = b; end
  endtask

  task automatic set_rr(input int p, input logic v);
    if (p == 0) resp0_ready = v;
    else        resp1_ready = v;
  endtask

  // One operation on port p; latency counted from the grant cycle (cycle 0).
  task automatic run_op(input int p, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold, output logic [31:0] r,
                        output logic e, output logic [1:0] fl, output int lat);
    int n;
    r = '0; e = 1'b0; fl = 2'b11; lat = -1;
    drive(p, 1'b1, f, a, b);
    #1;
    n = 0;
    while (!rdy(p) && n < 40) begin tick(); #1; n++; end
    if (!rdy(p)) begin timeout("grant_wait"); drive(p, 1'b0, f, a, b); return; end
    tick();
    drive(p, 1'b0, 4'h0, 32'h0, 32'h0);
    n = 1;
    while (!rvalid(p) && n < 40) begin tick(); n++; end
    if (!rvalid(p)) begin timeout("resp_wait"); return; end
    lat = n; r = rres(p); e = rerr(p); fl = flags;
    chk("other_port_quiet", {31'b0, rvalid(1 - p)} | rres(1 - p), 32'h0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", {31'b0, rvalid(p)}, 32'h1);
      chk("hold_result", rres(p), r);
    end
    set_rr(p, 1'b1);
    tick();
    set_rr(p, 1'b0);
    chk("resp_drop", {31'b0, rvalid(p)}, 32'h0);
  endtask

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a, b, res;
    logic        err;
    logic [1:0]  flg;
    int          lat;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] r;
  logic        e;
  logic [1:0]  fl, flg_m;
  int          lat, n, who, ptr_m;

  initial begin
    drive(0, 1'b1, FN_ADD, 32'd1, 32'd2);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    tbl[0]  = '{FN_ADD,   32'd5,      32'd7,      32'd12,         1'b0, FLAG_POS,  2};
    tbl[1]  = '{FN_CMP,   32'd3,      32'd3,      32'd0,          1'b0, FLAG_ZERO, 2};
    tbl[2]  = '{FN_ADD,   32'd1,      32'd1,      32'd2,          1'b0, FLAG_ZERO, 2};
    tbl[3]  = '{4'b1010,  32'd9,      32'd9,      32'd0,          1'b1, FLAG_ZERO, 2};
    tbl[4]  = '{FN_CMP,   32'd2,      32'd5,      32'hFFFF_FFFD,  1'b0, FLAG_NEG,  2};
    tbl[5]  = '{FN_CMP,   32'd8,      32'd1,      32'd7,          1'b0, FLAG_POS,  2};
    tbl[6]  = '{FN_ADD,   32'd100,    32'd23,     32'd123,        1'b0, FLAG_POS,  2};
    tbl[7]  = '{FN_MULT,  32'd6,      32'd7,      32'd42,         1'b0, FLAG_POS,  4};
    tbl[8]  = '{FN_SHL16, 32'h1234,   32'd0,      32'h1234_0000,  1'b0, FLAG_POS,  2};
    tbl[9]  = '{FN_NOT,   32'h0,      32'd0,      32'hFFFF_FFFF,  1'b0, FLAG_POS,  2};
    tbl[10] = '{FN_NOP,   32'd3,      32'd4,      32'd0,          1'b1, FLAG_POS,  2};
    tbl[11] = '{FN_AND,   32'hF0F0,   32'hFF00,   32'hF000,       1'b0, FLAG_POS,  2};

    // Reset values, with a request pending to show Ready is held low.
    #12;
    chk("rst_ready0", {31'b0, req0_ready}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_alufunc", {28'b0, alu_func}, 32'hF);
    chk("rst_alua", alu_a | alu_b, 32'h0);
    chk("rst_flags", {30'b0, flags}, 32'h0);
    chk("rst_resp", {30'b0, resp0_valid, resp1_valid} | resp0_result | resp1_result, 32'h0);
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(0, tbl[i].f, tbl[i].a, tbl[i].b, 0, r, e, fl, lat);
      $display("vec %0d func=%b result=%h err=%0d flags=%b lat=%0d", i, tbl[i].f, r, e, fl, lat);
      chk("vec_result", r, tbl[i].res);
      chk("vec_err", {31'b0, e}, {31'b0, tbl[i].err});
      chk("vec_flags", {30'b0, fl}, {30'b0, tbl[i].flg});
      chk("vec_latency", lat, tbl[i].lat);
    end

    // Asynchronous reset in the middle of EXEC discards the operation.
    run_op(0, FN_CMP, 32'd4, 32'd4, 0, r, e, fl, lat);
    chk("pre_rst_flags", {30'b0, fl}, {30'b0, FLAG_ZERO});
    drive(0, 1'b1, FN_ADD, 32'd5, 32'd7);
    #1;
    chk("midrst_grant", {31'b0, req0_ready}, 32'h1);
    tick();
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_alufunc", {28'b0, alu_func}, 32'hF);
    chk("midrst_alu_ops", alu_a | alu_b, 32'h0);
    chk("midrst_flags", {30'b0, flags}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_no_resp", {30'b0, resp0_valid, busy}, 32'h0);
    end
    $display("mid-EXEC reset sequence done");

    // Both requesters valid every cycle: grants must alternate.
    ptr_m = 0;
    drive(0, 1'b1, FN_SUB, 32'd9, 32'd4);
    drive(1, 1'b1, FN_XOR, 32'hF0, 32'h0F);
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 40) begin tick(); #1; n++; end
      if (!(req0_ready || req1_ready)) begin timeout("contend_grant"); break; end
      chk("one_ready", {31'b0, req0_ready & req1_ready}, 32'h0);
      who = req1_ready ? 1 : 0;
      chk("grant_order", who, ptr_m);
      ptr_m = 1 - ptr_m;
      tick();
      n = 1;
      while (!rvalid(who) && n < 40) begin tick(); n++; end
      if (!rvalid(who)) begin timeout("contend_resp"); break; end
      $display("contend grant=%0d result=%h", who, rres(who));
      chk("contend_result", rres(who), (who == 1) ? 32'hFF : 32'd5);
      chk("contend_other_quiet", {31'b0, rvalid(1 - who)}, 32'h0);
      set_rr(who, 1'b1);
      tick();
      set_rr(who, 1'b0);
      #1;
    end
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // MULT with Req1 waiting and five cycles of response backpressure.
    drive(0, 1'b1, FN_MULT, 32'd6, 32'd7);
    #1;
    chk("mult_grant", {31'b0, req0_ready}, 32'h1);
    tick();
    drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b1, FN_ADD, 32'd1, 32'd2);
    #1;
    for (int c = 1; c <= MC; c++) begin
      chk("mult_exec_busy", {30'b0, busy, req1_ready}, 32'h2);
      chk("mult_exec_novalid", {31'b0, resp0_valid}, 32'h0);
      tick();
      #1;
    end
    chk("mult_valid_cycle", {31'b0, resp0_valid}, 32'h1);
    chk("mult_result", resp0_result, 32'd42);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", {30'b0, resp0_valid, busy}, 32'h3);
      chk("bp_result", resp0_result, 32'd42);
      chk("bp_req1_held", {31'b0, req1_ready}, 32'h0);
    end
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    #1;
    chk("req1_after_resp", {30'b0, req1_ready, busy}, 32'h2);
    $display("mult/backpressure sequence done");
    run_op(1, FN_ADD, 32'd1, 32'd2, 0, r, e, fl, lat);
    chk("req1_result", r, 32'd3);

    // Randomised operations against the reference model.
    flg_m = FLAG_POS;
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  f;
      logic [31:0] a, b, exp_r;
      logic        exp_e;
      int          p, hold;
      p    = $urandom_range(0, 1);
      f    = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      hold = $urandom_range(0, 2);
      run_op(p, f, a, b, hold, r, e, fl, lat);
      exp_e = (f > 4'd8);
      exp_r = exp_e ? 32'h0 : alu_ref(a, b, f);
      if (f == FN_CMP) begin
        if (exp_r == 32'h0)      flg_m = FLAG_ZERO;
        else if ($signed(exp_r) < 0) flg_m = FLAG_NEG;
        else                     flg_m = FLAG_POS;
      end
      $display("rand %0d port=%0d func=%b result=%h err=%0d flags=%b lat=%0d", i, p, f, r, e, fl, lat);
      chk("rand_result", r, exp_r);
      chk("rand_err", {31'b0, e}, {31'b0, exp_e});
      chk("rand_flags", {30'b0, fl}, {30'b0, flg_m});
      chk("rand_latency", lat, (f == FN_MULT) ? 1 + MC : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
